// File: rtl/regfile_writeback_queue.sv
// Writeback queue: buffers ALU and load results in order and drains
// one per cycle into the register-file write port, with bypass.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   alu_* / ld_*    valid/ready result inputs; load has priority
//   wb_hold         stalls draining while the write port is borrowed
//   rf_*            register-file write port (head entry)
//   q_reg*/q_hit*/q_data*  decode bypass lookups, youngest entry wins
//   busy_mask       one-hot OR of queued destinations (bit 0 is 0)
//   count           number of valid entries
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  input  logic                     wb_hold,
  output logic                     rf_reg_write,
  output logic [4:0]               rf_write_reg,
  output logic [XLEN-1:0]          rf_write_data,
  input  logic [4:0]               q_reg1,
  input  logic [4:0]               q_reg2,
  output logic                     q_hit1,
  output logic                     q_hit2,
  output logic [XLEN-1:0]          q_data1,
  output logic [XLEN-1:0]          q_data2,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW:0]     count_q, count_d;

  logic            full, empty;
  logic            ld_fire, alu_fire;
  logic            push, pop;
  logic [4:0]      push_rd;
  logic [XLEN-1:0] push_data;

  // Full is judged on the registered count only; a same-cycle pop
  // does not make room for a push.
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);

  assign ld_ready  = !full;
  assign alu_ready = !full && !ld_valid;

  assign ld_fire  = ld_valid && ld_ready;
  assign alu_fire = alu_valid && alu_ready;

  assign push_rd   = ld_fire ? ld_rd : alu_rd;
  assign push_data = ld_fire ? ld_data : alu_data;

  // Writes to x0 are consumed but never enqueued.
  assign push = (ld_fire || alu_fire) && (push_rd != 5'd0);
  assign pop  = !empty && !wb_hold;

  assign rf_reg_write  = pop;
  assign rf_write_reg  = empty ? 5'd0 : rd_q[head_q];
  assign rf_write_data = empty ? '0 : data_q[head_q];
  assign count         = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)
      head_d = head_q + 1'b1;
    if (push)
      tail_d = tail_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        rd_q[tail_q]   <= push_rd;
        data_q[tail_q] <= push_data;
      end
    end
  end

  // Walk oldest to youngest so the last match is the youngest.
  always_comb begin
    q_hit1    = 1'b0;
    q_hit2    = 1'b0;
    q_data1   = '0;
    q_data2   = '0;
    busy_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW+1)'(k) < count_q) begin
        busy_mask[rd_q[head_q + PW'(k)]] = 1'b1;
        if (q_reg1 != 5'd0 && rd_q[head_q + PW'(k)] == q_reg1) begin
          q_hit1  = 1'b1;
          q_data1 = data_q[head_q + PW'(k)];
        end
        if (q_reg2 != 5'd0 && rd_q[head_q + PW'(k)] == q_reg2) begin
          q_hit2  = 1'b1;
          q_data2 = data_q[head_q + PW'(k)];
        end
      end
    end
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue.
// Inputs change 1ns after a rising edge; outputs are checked mid-cycle.
module tb_regfile_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, wb_hold;
  logic        alu_ready, ld_ready;
  logic [4:0]  alu_rd, ld_rd, q_reg1, q_reg2;
  logic [31:0] alu_data, ld_data;
  logic        rf_reg_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        q_hit1, q_hit2;
  logic [31:0] q_data1, q_data2;
  logic [31:0] busy_mask;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_writeback_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_rd(ld_rd), .ld_data(ld_data),
    .wb_hold(wb_hold),
    .rf_reg_write(rf_reg_write),
    .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data),
    .q_reg1(q_reg1), .q_reg2(q_reg2),
    .q_hit1(q_hit1), .q_hit2(q_hit2),
    .q_data1(q_data1), .q_data2(q_data2),
    .busy_mask(busy_mask), .count(count)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cnt_exp [5] = '{4, 3, 3, 2, 1};

  initial begin
    rst = 1'b0;
    alu_valid = 1'b0; ld_valid = 1'b0; wb_hold = 1'b0;
    alu_rd = '0; ld_rd = '0; alu_data = '0; ld_data = '0;
    q_reg1 = '0; q_reg2 = '0;
    #1;

    // 1: reset with random inputs
    rst = 1'b1;
    alu_valid = 1'($urandom); ld_valid = 1'($urandom);
    wb_hold = 1'($urandom);
    alu_rd = 5'($urandom); ld_rd = 5'($urandom);
    alu_data = $urandom; ld_data = $urandom;
    tick();
    rst = 1'b0;
    alu_valid = 1'b0; ld_valid = 1'b0; wb_hold = 1'b0;
    #1;
    check("rst_we", rf_reg_write, 0);
    check("rst_cnt", count, 0);
    check("rst_busy", busy_mask, 0);
    check("rst_ardy", alu_ready, 1);
    check("rst_lrdy", ld_ready, 1);
    check("rst_wreg", rf_write_reg, 0);

    // 2: single write
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234;
    #1 check("s_ardy", alu_ready, 1);
    tick();
    alu_valid = 1'b0; q_reg1 = 5'd3;
    #1;
    check("s_we", rf_reg_write, 1);
    check("s_reg", rf_write_reg, 3);
    check("s_data", rf_write_data, 32'h1234);
    check("s_hit1", q_hit1, 1);
    check("s_qd1", q_data1, 32'h1234);
    check("s_busy", busy_mask, 32'h8);
    tick();
    check("s_we2", rf_reg_write, 0);
    check("s_busy2", busy_mask, 0);
    check("s_hit1b", q_hit1, 0);

    // 3: load/ALU collision under hold
    wb_hold = 1'b1;
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hAAAA;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hBBBB;
    q_reg2 = 5'd5;
    #1;
    check("c_ardy0", alu_ready, 0);
    check("c_lrdy", ld_ready, 1);
    tick();
    ld_valid = 1'b0;
    #1;
    check("c_ardy1", alu_ready, 1);
    check("c_cnt1", count, 1);
    check("c_qd2a", q_data2, 32'hAAAA);
    tick();
    alu_valid = 1'b0;
    #1;
    check("c_cnt2", count, 2);
    check("c_hit2", q_hit2, 1);
    check("c_qd2b", q_data2, 32'hBBBB);
    check("c_hold", rf_reg_write, 0);
    wb_hold = 1'b0;
    #1;
    check("c_we1", rf_reg_write, 1);
    check("c_reg1", rf_write_reg, 5);
    check("c_dat1", rf_write_data, 32'hAAAA);
    tick();
    check("c_we2", rf_reg_write, 1);
    check("c_dat2", rf_write_data, 32'hBBBB);
    tick();
    check("c_we3", rf_reg_write, 0);
    check("c_cnt3", count, 0);

    // 4: fill, stall, drain with wrap
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'h100 + i;
      tick();
    end
    alu_rd = 5'd5; alu_data = 32'h105;
    #1;
    check("f_cnt", count, 4);
    check("f_ardy", alu_ready, 0);
    check("f_lrdy", ld_ready, 0);
    check("f_busy", busy_mask, 32'h1E);
    tick();
    check("f_stall", count, 4);
    wb_hold = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      check("d_we", rf_reg_write, 1);
      check("d_reg", rf_write_reg, i);
      check("d_data", rf_write_data, 32'h100 + i);
      check("d_cnt", count, cnt_exp[i-1]);
      if (i == 1) check("d_ardy1", alu_ready, 0);
      if (i == 2) check("d_ardy2", alu_ready, 1);
      tick();
      if (i == 2) alu_valid = 1'b0;
    end
    check("d_end_cnt", count, 0);
    check("d_end_we", rf_reg_write, 0);

    // 5: writes to x0 are dropped
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    q_reg1 = 5'd0;
    #1 check("z_ardy", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    #1;
    check("z_cnt", count, 0);
    check("z_we", rf_reg_write, 0);
    check("z_hit1", q_hit1, 0);
    check("z_qd1", q_data1, 0);

    // 6: reset discards queued writes
    wb_hold = 1'b1;
    for (int i = 7; i <= 9; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'h200 + i;
      tick();
    end
    alu_valid = 1'b0;
    #1;
    check("r_cnt3", count, 3);
    check("r_busy3", busy_mask, 32'h380);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("r_cnt0", count, 0);
    check("r_busy0", busy_mask, 0);
    wb_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("r_nowe", rf_reg_write, 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Initiator side of the register-file write port: accepts writeback results from the ALU and the load unit and buffers them in an in-order FIFO.
- Drains one entry per cycle into the register file's write port (reg_write / write_reg / write_data).
- Exposes a pending-write scoreboard and read bypass so decode sees values still queued or being written this cycle.
- Sits between execute/memory stages and the register file.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
XLEN, 32, data width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU result accepted this cycle when alu_valid && alu_ready
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
ld_valid  input  1  load result offered
ld_ready  output  1  load result accepted this cycle when ld_valid && ld_ready
ld_rd  input  5  load destination register
ld_data  input  XLEN  load result
wb_hold  input  1  write port borrowed elsewhere; blocks draining
rf_reg_write  output  1  to register file reg_write
rf_write_reg  output  5  to register file write_reg
rf_write_data  output  XLEN  to register file write_data
q_reg1  input  5  decode read address 1
q_reg2  input  5  decode read address 2
q_hit1  output  1  q_reg1 has a queued write
q_hit2  output  1  q_reg2 has a queued write
q_data1  output  XLEN  youngest queued data for q_reg1; 0 when no hit
q_data2  output  XLEN  youngest queued data for q_reg2; 0 when no hit
busy_mask  output  32  bit r set if any valid entry targets register r; bit 0 always 0
count  output  $clog2(DEPTH)+1  valid entries

Behaviour:
- Reset (rst high at an edge): head/tail pointers and count cleared, all entries invalid. Queued writes are discarded, not drained.
- After reset: rf_reg_write=0, rf_write_reg=0, rf_write_data=0, busy_mask=0, q_hit*=0, q_data*=0, count=0, ld_ready=1, alu_ready=1.
- Readies (combinational):
  - ld_ready = !full.
  - alu_ready = !full && !ld_valid.
  - Load has fixed priority because it is the older instruction. At most one push per cycle.
  - full is based on the current count; a same-cycle pop does not free a slot.
- Push:
  - An accepted request with rd != 0 writes {rd, data} at the tail; tail and count advance at the edge.
  - An accepted request with rd == 0 is consumed (ready honoured), not enqueued, with no other effect.
- Drain:
  - rf_reg_write = !empty && !wb_hold. rf_write_reg and rf_write_data come from the head entry; both are 0 when empty.
  - When rf_reg_write=1, the head pops at the same edge at which the register file captures it.
  - Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- Latency: a result accepted at edge N is presented on rf_* during cycle N+1 with no hold and an otherwise empty queue. It is in the register file after edge N+1.
- Bypass (combinational over all valid entries, including the head being written this cycle):
  - Youngest matching entry wins.
  - q_regX == 0 gives hit 0 and data 0.
  - Entries accepted this cycle are not visible until after the edge.
- busy_mask: OR over valid entries of the one-hot rd. It updates with the push/pop edge.
- wb_hold may toggle freely. While it is high, pushes continue until full, and order is strictly preserved.

Test Plan:
1. Reset: drive rst=1 for 1 cycle with random inputs. Required: rf_reg_write=0, count=0, busy_mask=0, alu_ready=1, ld_ready=1.
2. Single write: alu rd=3, data=0x00001234 accepted at cycle 0. Required in cycle 1: rf_reg_write=1, rf_write_reg=3, rf_write_data=0x00001234; q_reg1=3 gives q_hit1=1, q_data1=0x00001234; busy_mask=0x8. Required in cycle 2: rf_reg_write=0, busy_mask=0.
3. Collision, with wb_hold=1: ld rd=5, 0xAAAA and alu rd=5, 0xBBBB offered together. Required:
   - Load accepted first with alu_ready=0; ALU accepted the next cycle.
   - q_reg2=5 gives q_data2=0xBBBB.
   - After hold release, the register file is written 0xAAAA then 0xBBBB on consecutive cycles.
4. Full/wrap: wb_hold=1, push rd=1..5.
   - After 4 pushes: count=4, both readies 0; the 5th offer stalls.
   - Release hold: rd 1,2,3,4 are written in order, then 5 is accepted and written. Pointers wrap correctly.
5. x0: alu rd=0, data=0xFFFF. Required: alu_ready=1, count stays 0, rf_reg_write never asserts, q_reg1=0 gives q_hit1=0.
6. Reset mid-operation: wb_hold=1 with 3 entries queued, assert rst. Required: count=0, busy_mask=0, and no rf_reg_write after hold release.
